// File: rtl/layer_readout_scheduler.sv
// -----------------------------------------------------------------------------
// layer_readout_scheduler
//
// Round-robin readout scheduler for the AstroPix layer rows. Synchronizes the
// active-low per-layer interrupts, grants one layer at a time to the shared
// readout engine, sequences that layer's hold line around the grant, guards the
// readout with a timeout, and produces the MEB-facing fee_hit / fee_busy lines.
//
// Ports:
//   sysclk            - single system clock
//   warm_resn         - asynchronous active-low reset
//   layer_interruptn  - per-layer interrupt, active low, asynchronous
//   layer_enable      - per-layer mask, 0 ignores the layer
//   meb_hold          - MEB full, blocks new grants while high
//   readout_done      - one-cycle pulse when the granted layer is drained
//   readout_start     - one-cycle grant pulse to the readout engine
//   readout_layer     - granted layer index, stable for the whole grant
//   layer_hold        - one-hot hold line to the granted layer
//   fee_hit           - active-low hit pulse to the MEB
//   fee_busy          - high while a grant is in progress or meb_hold is high
//   pending           - synchronized, masked request vector (status)
//   timeout_err       - one-cycle pulse when a readout times out
//   timeout_count     - saturating count of timeouts
// -----------------------------------------------------------------------------
module layer_readout_scheduler #(
  parameter int NUM_LAYERS     = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_SETUP     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int HIT_PULSE      = 8,
  localparam int LW            = $clog2(NUM_LAYERS)
) (
  input  logic                  sysclk,
  input  logic                  warm_resn,
  input  logic [NUM_LAYERS-1:0] layer_interruptn,
  input  logic [NUM_LAYERS-1:0] layer_enable,
  input  logic                  meb_hold,
  input  logic                  readout_done,
  output logic                  readout_start,
  output logic [LW-1:0]         readout_layer,
  output logic [NUM_LAYERS-1:0] layer_hold,
  output logic                  fee_hit,
  output logic                  fee_busy,
  output logic [NUM_LAYERS-1:0] pending,
  output logic                  timeout_err,
  output logic [15:0]           timeout_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [15:0]   SETUP_LOAD   = 16'(HOLD_SETUP - 1);
  localparam logic [15:0]   TMO_LOAD     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    HIT_LOAD     = 8'(HIT_PULSE);
  localparam logic [LW:0]   NUM_LAYERS_W = (LW+1)'(NUM_LAYERS);
  localparam logic [LW-1:0] LAST_IDX     = LW'(NUM_LAYERS - 1);

  logic [NUM_LAYERS-1:0] sync_r [SYNC_STAGES];
  logic [NUM_LAYERS-1:0] req_s;
  logic                  any_req_s;
  logic                  any_req_r;
  logic [7:0]            hit_cnt_r;
  logic [7:0]            hit_next_s;
  logic [2:0]            state_r;
  logic [15:0]           cnt_r;
  logic [LW-1:0]         rr_ptr_r;
  logic [LW-1:0]         win_idx_s;
  logic                  win_found_s;
  logic [LW:0]           cand_s;
  logic                  cand_hit_s;

  // Interrupt synchronizer chain; flops idle at 1 (interrupt inactive).
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= {NUM_LAYERS{1'b1}};
      end
    end else begin
      sync_r[0] <= layer_interruptn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign req_s     = ~sync_r[SYNC_STAGES-1] & layer_enable;
  assign any_req_s = |req_s;

  // Hit pulse counter: a rising edge of any request (re)loads the pulse width.
  always_comb begin
    hit_next_s = 8'd0;
    if (any_req_s && !any_req_r) begin
      hit_next_s = HIT_LOAD;
    end else if (hit_cnt_r != 8'd0) begin
      hit_next_s = hit_cnt_r - 8'd1;
    end else begin
      hit_next_s = 8'd0;
    end
  end

  // Registered request status and hit pulse output.
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      pending   <= {NUM_LAYERS{1'b0}};
      any_req_r <= 1'b0;
      hit_cnt_r <= 8'd0;
      fee_hit   <= 1'b1;
    end else begin
      pending   <= req_s;
      any_req_r <= any_req_s;
      hit_cnt_r <= hit_next_s;
      fee_hit   <= (hit_next_s == 8'd0);
    end
  end

  // Round-robin search over the registered requests, starting at rr_ptr_r.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {LW{1'b0}};
    cand_s      = {(LW+1){1'b0}};
    cand_hit_s  = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      cand_s      = {1'b0, rr_ptr_r} + (LW+1)'(k);
      cand_s      = (cand_s >= NUM_LAYERS_W) ? (cand_s - NUM_LAYERS_W) : cand_s;
      cand_hit_s  = pending[cand_s[LW-1:0]] & ~win_found_s;
      win_idx_s   = cand_hit_s ? cand_s[LW-1:0] : win_idx_s;
      win_found_s = win_found_s | cand_hit_s;
    end
  end

  // Grant sequencer: hold setup, start pulse, timed readout, release.
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 16'd0;
      rr_ptr_r      <= {LW{1'b0}};
      readout_start <= 1'b0;
      readout_layer <= {LW{1'b0}};
      layer_hold    <= {NUM_LAYERS{1'b0}};
      timeout_err   <= 1'b0;
      timeout_count <= 16'd0;
    end else begin
      readout_start <= 1'b0;
      timeout_err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (win_found_s && !meb_hold) begin
            readout_layer <= win_idx_s;
            layer_hold    <= {{(NUM_LAYERS-1){1'b0}}, 1'b1} << win_idx_s;
            cnt_r         <= SETUP_LOAD;
            state_r       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // start is registered, so it is raised on the edge entering START
          if (cnt_r == 16'd0) begin
            readout_start <= 1'b1;
            state_r       <= ST_START;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_START: begin
          cnt_r   <= TMO_LOAD;
          state_r <= ST_READ;
        end
        ST_READ: begin
          // done wins over a timeout expiring in the same cycle; the final
          // wait cycle is cnt_r==1 so the error pulse lands TIMEOUT_CYCLES
          // cycles after readout_start.
          if (readout_done) begin
            state_r <= ST_RELEASE;
          end else if (cnt_r <= 16'd1) begin
            timeout_err <= 1'b1;
            if (timeout_count != 16'hFFFF) begin
              timeout_count <= timeout_count + 16'd1;
            end
            state_r <= ST_RELEASE;
          end else begin
            cnt_r <= cnt_r - 16'd1;
          end
        end
        ST_RELEASE: begin
          layer_hold <= {NUM_LAYERS{1'b0}};
          rr_ptr_r   <= (readout_layer == LAST_IDX) ? {LW{1'b0}}
                                                    : readout_layer + LW'(1);
          state_r    <= ST_IDLE;
        end
        default: begin
          layer_hold <= {NUM_LAYERS{1'b0}};
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // Busy indication to the MEB.
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      fee_busy <= 1'b0;
    end else begin
      fee_busy <= (state_r != ST_IDLE) || meb_hold;
    end
  end

endmodule

// File: tb/tb_layer_readout_scheduler.sv
module tb_layer_readout_scheduler;

  localparam int N  = 20;
  localparam int LW = 5;
  localparam int HS = 4;
  localparam int TO = 16;
  localparam int HP = 8;

  logic          sysclk = 1'b0;
  logic          warm_resn;
  logic [N-1:0]  layer_interruptn;
  logic [N-1:0]  layer_enable;
  logic          meb_hold;
  logic          readout_done;
  logic          readout_start;
  logic [LW-1:0] readout_layer;
  logic [N-1:0]  layer_hold;
  logic          fee_hit;
  logic          fee_busy;
  logic [N-1:0]  pending;
  logic          timeout_err;
  logic [15:0]   timeout_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int start_cyc  = 0;
  int exp_q[$];

  layer_readout_scheduler #(
    .NUM_LAYERS(N), .SYNC_STAGES(2), .HOLD_SETUP(HS),
    .TIMEOUT_CYCLES(TO), .HIT_PULSE(HP)
  ) dut (
    .sysclk(sysclk), .warm_resn(warm_resn),
    .layer_interruptn(layer_interruptn), .layer_enable(layer_enable),
    .meb_hold(meb_hold), .readout_done(readout_done),
    .readout_start(readout_start), .readout_layer(readout_layer),
    .layer_hold(layer_hold), .fee_hit(fee_hit), .fee_busy(fee_busy),
    .pending(pending), .timeout_err(timeout_err), .timeout_count(timeout_count)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Wait (bounded) for a readout_start pulse and score its layer.
  task automatic expect_grant(input string tag, input int budget);
    int waited;
    int exp_layer;
    waited = 0;
    while (readout_start !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    if (readout_start === 1'b1) begin
      start_cyc = cyc;
      exp_layer = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      check(tag, 32'(readout_layer), 32'(exp_layer));
    end else begin
      check({tag, " start_seen"}, 32'(readout_start), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_start;
    int saw;
    logic [31:0] hold_exp;

    warm_resn        = 1'b0;
    layer_interruptn = {N{1'b1}};
    layer_enable     = {N{1'b1}};
    meb_hold         = 1'b0;
    readout_done     = 1'b0;

    // ---------------- reset values
    tick(); tick();
    check("rst readout_start", 32'(readout_start), 32'd0);
    check("rst readout_layer", 32'(readout_layer), 32'd0);
    check("rst layer_hold",    32'(layer_hold),    32'd0);
    check("rst fee_hit",       32'(fee_hit),       32'd1);
    check("rst fee_busy",      32'(fee_busy),      32'd0);
    check("rst pending",       32'(pending),       32'd0);
    check("rst timeout_err",   32'(timeout_err),   32'd0);
    check("rst timeout_count", 32'(timeout_count), 32'd0);
    warm_resn = 1'b1;
    tick(); tick();

    // ---------------- single request on layer 5, cycle-by-cycle
    layer_interruptn[5] = 1'b0;
    exp_q.push_back(5);
    hold_exp = 32'd1 << 5;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("single pending t%0d", t), 32'(pending),
            (t >= 3 && t <= 10) ? hold_exp : 32'd0);
      check($sformatf("single fee_hit t%0d", t), 32'(fee_hit),
            (t >= 3 && t <= 10) ? 32'd0 : 32'd1);
      check($sformatf("single hold t%0d", t), 32'(layer_hold),
            (t >= 4 && t <= 10) ? hold_exp : 32'd0);
      check($sformatf("single start t%0d", t), 32'(readout_start),
            (t == 4 + HS) ? 32'd1 : 32'd0);
      check($sformatf("single busy t%0d", t), 32'(fee_busy),
            (t >= 5 && t <= 11) ? 32'd1 : 32'd0);
      if (t == 4 + HS) begin
        check("single layer", 32'(readout_layer), 32'(exp_q.pop_front()));
        layer_interruptn[5] = 1'b1;
      end
      readout_done = (t == 5 + HS);
    end
    readout_done = 1'b0;

    // ---------------- fairness: layers 0, 7, 19 from rr_ptr = 0
    warm_resn = 1'b0;
    tick();
    warm_resn = 1'b1;
    tick();
    layer_interruptn[0]  = 1'b0;
    layer_interruptn[7]  = 1'b0;
    layer_interruptn[19] = 1'b0;
    for (int g = 0; g < 10; g++) begin
      exp_q.push_back(0);
      exp_q.push_back(7);
      exp_q.push_back(19);
    end
    prev_start = 0;
    for (int g = 0; g < 30; g++) begin
      expect_grant($sformatf("rr grant %0d", g), 40);
      if (g > 0) check($sformatf("rr spacing %0d", g), 32'(start_cyc - prev_start), 32'(HS + 4));
      prev_start = start_cyc;
      if (g == 29) layer_interruptn = {N{1'b1}};
      tick();
      readout_done = 1'b1;
      tick();
      readout_done = 1'b0;
    end
    saw = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (readout_start === 1'b1) saw++;
    end
    check("rr no extra grant", 32'(saw), 32'd0);

    // ---------------- masking: layer 3 disabled
    layer_enable[3]     = 1'b0;
    layer_interruptn[3] = 1'b0;
    saw = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (readout_start !== 1'b0 || fee_hit !== 1'b1 || pending !== '0) saw++;
    end
    check("mask no grant/hit", 32'(saw), 32'd0);
    layer_interruptn[3] = 1'b1;
    tick(); tick(); tick(); tick();
    layer_enable[3] = 1'b1;
    tick();

    // ---------------- backpressure: meb_hold blocks layer 2
    meb_hold            = 1'b1;
    layer_interruptn[2] = 1'b0;
    exp_q.push_back(2);
    saw = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (readout_start !== 1'b0 || layer_hold !== '0) saw++;
    end
    check("hold no grant", 32'(saw), 32'd0);
    check("hold fee_busy", 32'(fee_busy), 32'd1);
    check("hold pending", 32'(pending), 32'd1 << 2);
    meb_hold            = 1'b0;
    layer_interruptn[4] = 1'b0;
    exp_q.push_back(4);
    tick();
    check("hold grant after release", 32'(layer_hold), 32'd1 << 2);
    expect_grant("hold grant layer", 10);

    // ---------------- timeout with no readout_done
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("tmo err k%0d", k), 32'(timeout_err), (k == TO) ? 32'd1 : 32'd0);
      if (k == TO) check("tmo count", 32'(timeout_count), 32'd1);
    end
    expect_grant("tmo next grant", 20);
    layer_interruptn[2] = 1'b1;
    layer_interruptn[4] = 1'b1;

    // ---------------- done in the final timeout cycle
    for (int k = 1; k <= 20; k++) begin
      tick();
      readout_done = (k == TO - 1);
      check($sformatf("race err k%0d", k), 32'(timeout_err), 32'd0);
    end
    readout_done = 1'b0;
    check("race count", 32'(timeout_count), 32'd1);
    check("race hold released", 32'(layer_hold), 32'd0);

    // ---------------- saturation of timeout_count
    force dut.timeout_count = 16'hFFFF;
    tick();
    release dut.timeout_count;
    tick();
    check("sat preload", 32'(timeout_count), 32'hFFFF);
    layer_interruptn[11] = 1'b0;
    exp_q.push_back(11);
    expect_grant("sat grant", 20);
    layer_interruptn[11] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("sat err k%0d", k), 32'(timeout_err), (k == TO) ? 32'd1 : 32'd0);
    end
    check("sat count", 32'(timeout_count), 32'hFFFF);

    // ---------------- reset during SETUP of layer 9
    layer_interruptn[9] = 1'b0;
    saw = 0;
    for (int t = 0; t < 20 && saw == 0; t++) begin
      tick();
      if (layer_hold[9] === 1'b1) saw = 1;
    end
    check("rstmid hold seen", 32'(saw), 32'd1);
    tick();
    warm_resn = 1'b0;
    #1;
    check("rstmid hold",          32'(layer_hold),    32'd0);
    check("rstmid start",         32'(readout_start), 32'd0);
    check("rstmid layer",         32'(readout_layer), 32'd0);
    check("rstmid fee_hit",       32'(fee_hit),       32'd1);
    check("rstmid fee_busy",      32'(fee_busy),      32'd0);
    check("rstmid pending",       32'(pending),       32'd0);
    check("rstmid timeout_count", 32'(timeout_count), 32'd0);
    layer_interruptn = {N{1'b1}};
    tick(); tick();
    warm_resn = 1'b1;
    saw = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (readout_start !== 1'b0 || layer_hold !== '0) saw++;
    end
    check("rstmid no start", 32'(saw), 32'd0);
    layer_interruptn[12] = 1'b0;
    layer_interruptn[3]  = 1'b0;
    exp_q.push_back(3);
    expect_grant("rstmid search from 0", 20);
    layer_interruptn = {N{1'b1}};
    tick();
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
